regfile_scoreboard: RTL

Parametrised general-purpose register bank for the bus-based CPU, replacing the fixed sixteen discrete 32-bit registers and the special R0 register. It provides two asynchronous read ports, one synchronous write port, R0 base-address zeroing, an optional write-to-read bypass, and a per-register pending scoreboard. The scoreboard lets multi-cycle units such as MUL/DIV into HI/LO or memory loads reserve a destination and stall dependent reads until writeback.

---
 rtl/regfile_scoreboard_if.sv | 41 ++++
 rtl/regfile_scoreboard.sv | 130 +++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// Register-bank bus: two read ports, one write port and the issue/reserve
// channel. The requester side (CPU datapath) uses the master modport.
interface regfile_scoreboard_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    logic [AW-1:0]    rd_a_addr;
    logic             ba_a;
    logic [WIDTH-1:0] rd_a_data;
    logic             hazard_a;

    logic [AW-1:0]    rd_b_addr;
    logic [WIDTH-1:0] rd_b_data;
    logic             hazard_b;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    logic             issue_en;
    logic [AW-1:0]    issue_addr;
    logic             issue_ok;

    logic [AW:0]      pending_cnt;

    modport master (
        output rd_a_addr, ba_a, rd_b_addr,
        output wr_en, wr_addr, wr_data,
        output issue_en, issue_addr,
        input  rd_a_data, hazard_a, rd_b_data, hazard_b,
        input  issue_ok, pending_cnt
    );

    modport slave (
        input  rd_a_addr, ba_a, rd_b_addr,
        input  wr_en, wr_addr, wr_data,
        input  issue_en, issue_addr,
        output rd_a_data, hazard_a, rd_b_data, hazard_b,
        output issue_ok, pending_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// General-purpose register bank with two combinational read ports, one
// synchronous write port, R0 base-address zeroing on port A, optional
// write-to-read forwarding and a per-register pending scoreboard.
module regfile_scoreboard #(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 16,
    parameter int AW     = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 clr,
    regfile_scoreboard_if.slave  bus
);
    logic [WIDTH-1:0] r_mem [NREGS];
    logic [NREGS-1:0] r_pend;
    logic [AW:0]      r_cnt;

    logic [WIDTH-1:0] w_mem_a;
    logic [WIDTH-1:0] w_mem_b;
    logic             w_pend_a;
    logic             w_pend_b;
    logic             w_pend_iss;
    logic             w_pend_wr;
    logic             w_wr_hit;
    logic             w_fwd_a;
    logic             w_fwd_b;
    logic             w_issue_ok;
    logic             w_same_reg;
    logic             w_set_eff;
    logic             w_clr_eff;
    logic [NREGS-1:0] w_pend_nxt;
    logic [AW:0]      w_cnt_nxt;

    // Address lookups; an index outside 0..NREGS-1 matches nothing and reads 0.
    always_comb begin
        w_mem_a    = '0;
        w_mem_b    = '0;
        w_pend_a   = 1'b0;
        w_pend_b   = 1'b0;
        w_pend_iss = 1'b0;
        w_pend_wr  = 1'b0;
        w_wr_hit   = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (bus.rd_a_addr == AW'(i)) begin
                w_mem_a  = r_mem[i];
                w_pend_a = r_pend[i];
            end
            if (bus.rd_b_addr == AW'(i)) begin
                w_mem_b  = r_mem[i];
                w_pend_b = r_pend[i];
            end
            if (bus.issue_addr == AW'(i)) begin
                w_pend_iss = r_pend[i];
            end
            if (bus.wr_addr == AW'(i)) begin
                w_pend_wr = r_pend[i];
                w_wr_hit  = bus.wr_en;
            end
        end
    end

    // Forwarding only applies to an in-range write, so w_wr_hit gates it.
    assign w_fwd_a = BYPASS && w_wr_hit && (bus.wr_addr == bus.rd_a_addr);
    assign w_fwd_b = BYPASS && w_wr_hit && (bus.wr_addr == bus.rd_b_addr);

    // Read port data selection.
    always_comb begin
        if (bus.ba_a && (bus.rd_a_addr == '0)) begin
            bus.rd_a_data = '0;
        end else if (w_fwd_a) begin
            bus.rd_a_data = bus.wr_data;
        end else begin
            bus.rd_a_data = w_mem_a;
        end
        if (w_fwd_b) begin
            bus.rd_b_data = bus.wr_data;
        end else begin
            bus.rd_b_data = w_mem_b;
        end
    end

    assign bus.hazard_a = w_pend_a & ~w_fwd_a;
    assign bus.hazard_b = w_pend_b & ~w_fwd_b;

    // A pending register may be re-reserved in the cycle its writeback lands.
    assign w_same_reg = w_wr_hit && (bus.wr_addr == bus.issue_addr);
    assign w_issue_ok = bus.issue_en && (~w_pend_iss || w_same_reg)
                        && (w_pend_iss || w_issue_in_range());
    assign bus.issue_ok    = w_issue_ok;
    assign bus.pending_cnt = r_cnt;

    function automatic logic w_issue_in_range();
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (bus.issue_addr == AW'(i)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Count deltas derived from the same set/clear that drives the next
    // pending vector; a collision on one register leaves the count alone.
    assign w_set_eff = w_issue_ok & ~w_pend_iss;
    assign w_clr_eff = w_wr_hit & w_pend_wr & ~(w_issue_ok & w_same_reg);

    // Next-state pending vector: writeback clears, issue sets afterwards.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < NREGS; i++) begin
            if (w_wr_hit && (bus.wr_addr == AW'(i))) w_pend_nxt[i] = 1'b0;
            if (w_issue_ok && (bus.issue_addr == AW'(i))) w_pend_nxt[i] = 1'b1;
        end
        w_cnt_nxt = r_cnt + {{AW{1'b0}}, w_set_eff} - {{AW{1'b0}}, w_clr_eff};
    end

    // Register storage, scoreboard and count; clr overrides everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (bus.wr_en && (bus.wr_addr == AW'(i))) r_mem[i] <= bus.wr_data;
            end
            r_pend <= w_pend_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end
endmodule
